decimator: RTL and testbench

Averaging decimator placed directly after the microphone FIR low-pass stage. It takes the filtered 24-bit signed sample stream, averages each block of 2^DECIM_LOG2 consecutive samples into one output sample, and reduces the rate from 48 kHz to 6 kHz at default settings. It frames the output stream for the FFT by asserting `m_axis_tlast` every FRAME_LEN output samples. Both sides are AXI-Stream; backpressure from the FFT propagates upstream.

---
 rtl/decimator.sv | 61 ++++++
 tb/tb_decimator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/decimator.sv
// decimator: block-average decimator (2^DECIM_LOG2 : 1) with AXI-Stream framing via tlast every FRAME_LEN outputs
module decimator #(
  parameter int DATA_WIDTH = 24,
  parameter int DECIM_LOG2 = 3,
  parameter int FRAME_LEN  = 512
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast
);
  localparam int AW = DATA_WIDTH + DECIM_LOG2;
  localparam int FW = $clog2(FRAME_LEN);
  logic [DECIM_LOG2-1:0] phase_q, phase_d;
  logic signed [AW-1:0] acc_q, acc_d, samp, sum;
  logic [FW-1:0] frame_q, frame_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic last, accept, load, wrap;
  always_comb begin
    last = &phase_q;
    s_axis_tready = !last || !tvalid_q || m_axis_tready;
    accept = s_axis_tvalid && s_axis_tready;
    load = accept && last;
    wrap = frame_q == FW'(FRAME_LEN - 1);
    samp = {{DECIM_LOG2{s_axis_tdata[DATA_WIDTH-1]}}, s_axis_tdata};
    sum = acc_q + samp;
    phase_d = accept ? phase_q + 1'b1 : phase_q;
    acc_d = accept ? (phase_q == '0 ? samp : sum) : acc_q;
    frame_d = load ? (wrap ? '0 : frame_q + 1'b1) : frame_q;
    // dropping the low DECIM_LOG2 bits is the arithmetic shift, rounding toward -inf
    tdata_d = load ? sum[AW-1:DECIM_LOG2] : tdata_q;
    tlast_d = load ? wrap : tlast_q;
    tvalid_d = load || (tvalid_q && !m_axis_tready);
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      phase_q  <= '0;
      acc_q    <= '0;
      frame_q  <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      acc_q    <= acc_d;
      frame_q  <= frame_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
    end
  end
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
endmodule

// File: tb/tb_decimator.sv
// tb_decimator: table vectors plus scoreboarded streams for the averaging decimator (FRAME_LEN=4)
module tb_decimator;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
  logic [23:0] s_axis_tdata = '0;
  logic m_axis_tvalid;
  logic m_axis_tready = 1'b1;
  logic [23:0] m_axis_tdata;
  logic m_axis_tlast;

  decimator #(.DATA_WIDTH(24), .DECIM_LOG2(3), .FRAME_LEN(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [23:0] d;
    logic        l;
  } exp_t;
  typedef struct packed {
    logic [7:0][23:0] s;
    logic [23:0]      e;
  } vec_t;

  exp_t q[$];
  vec_t tbl[6];
  int n_chk = 0;
  int n_fail = 0;
  longint acc = 0;
  int ph = 0;
  int fr = 0;
  bit ovr = 1'b0;
  logic [23:0] ovr_d = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output handshake completes at the next rising edge; inputs are stable by the falling edge.
  always @(negedge clk_in) begin
    if (rst_in && m_axis_tvalid && m_axis_tready) begin
      if (q.size() == 0) chk("spurious_output", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", longint'(m_axis_tdata), longint'(e.d));
        chk("out_last", longint'(m_axis_tlast), longint'(e.l));
      end
    end
  end

  task automatic model_accept(input logic [23:0] d);
    longint v;
    longint avg;
    exp_t e;
    v = longint'($signed(d));
    acc = (ph == 0) ? v : acc + v;
    if (ph == 7) begin
      avg = acc >>> 3;
      e.d = ovr ? ovr_d : avg[23:0];
      e.l = (fr == 3);
      q.push_back(e);
      fr = (fr + 1) % 4;
      chk("load_latency_tvalid", longint'(m_axis_tvalid), 1);
    end
    ph = (ph + 1) % 8;
  endtask

  task automatic send_sample(input logic [23:0] d);
    bit ok;
    ok = 1'b0;
    s_axis_tdata = d;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (s_axis_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("input_timeout", 0, 1);
      s_axis_tvalid = 1'b0;
    end else begin
      @(posedge clk_in);
      #1;
      s_axis_tvalid = 1'b0;
      model_accept(d);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk_in);
    @(negedge clk_in);
    chk("drain_all", longint'(q.size()), 0);
  endtask

  task automatic do_reset();
    @(posedge clk_in);
    #3;
    rst_in = 1'b0;
    q.delete();
    ph = 0;
    fr = 0;
    acc = 0;
    @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 6; k++) tbl[k] = '0;
    tbl[0].s[0] = 24'hFFFFFF;
    tbl[0].e = 24'hFFFFFF;
    for (int j = 0; j < 8; j++) tbl[1].s[j] = 24'(j);
    tbl[1].e = 24'd3;
    tbl[2].s[0] = 24'hFFFFF8;
    tbl[2].e = 24'hFFFFFF;
    for (int j = 0; j < 8; j++) tbl[3].s[j] = 24'h7FFFFF;
    tbl[3].e = 24'h7FFFFF;
    for (int j = 0; j < 8; j++) tbl[4].s[j] = 24'h800000;
    tbl[4].e = 24'h800000;
    for (int j = 0; j < 8; j++) tbl[5].s[j] = j[0] ? 24'h800000 : 24'h7FFFFF;
    tbl[5].e = 24'hFFFFFF;

    #12;
    chk("reset_tvalid", longint'(m_axis_tvalid), 0);
    chk("reset_tdata", longint'(m_axis_tdata), 0);
    chk("reset_tlast", longint'(m_axis_tlast), 0);
    chk("reset_s_tready", longint'(s_axis_tready), 1);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // constant input: two outputs of 1000, tlast low
    for (int i = 0; i < 16; i++) send_sample(24'd1000);
    wait_drain();

    // sign, rounding and full-scale vectors
    do_reset();
    ovr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ovr_d = tbl[k].e;
      for (int j = 0; j < 8; j++) send_sample(tbl[k].s[j]);
    end
    ovr = 1'b0;
    wait_drain();

    // backpressure: samples 1..24, averages 4, 12, 20
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 15; i++) send_sample(24'(i));
    s_axis_tdata = 24'd16;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      chk("bp_hold_tvalid", longint'(m_axis_tvalid), 1);
      chk("bp_hold_tdata", longint'(m_axis_tdata), 4);
      chk("bp_s_tready_low", longint'(s_axis_tready), 0);
    end
    @(posedge clk_in);
    #1;
    m_axis_tready = 1'b1;
    @(negedge clk_in);
    chk("bp_s_tready_release", longint'(s_axis_tready), 1);
    @(posedge clk_in);
    #1;
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0;
    model_accept(24'd16);
    chk("bp_no_bubble_tdata", longint'(m_axis_tdata), 12);
    m_axis_tready = 1'b1;
    for (int i = 17; i <= 24; i++) send_sample(24'(i));
    wait_drain();

    // framing: 40 samples, tlast only on the 4th output
    do_reset();
    for (int i = 0; i < 40; i++) send_sample(24'(i * 37 - 500));
    wait_drain();

    // asynchronous reset with a partial block and an unsent output
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 13; i++) send_sample(24'd9999);
    @(negedge clk_in);
    chk("pre_reset_tvalid", longint'(m_axis_tvalid), 1);
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    #1;
    chk("async_rst_tvalid", longint'(m_axis_tvalid), 0);
    chk("async_rst_tdata", longint'(m_axis_tdata), 0);
    chk("async_rst_tlast", longint'(m_axis_tlast), 0);
    q.delete();
    ph = 0;
    fr = 0;
    acc = 0;
    #1;
    rst_in = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 32; i++) send_sample(24'd200);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
